atm_balance_arbiter: RTL and testbench

ATM_BALANCE_ARBITER -- requirements
Module: atm_balance_arbiter

---
 rtl/atm_balance_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_atm_balance_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_balance_arbiter.sv
// -----------------------------------------------------------------------------
// atm_balance_arbiter
//
// Two ATM controllers share one 64-bit account balance. A round-robin arbiter
// grants one requester at a time. The granted transaction (deposit or
// withdraw) is captured, executed in one cycle and reported with a one-cycle
// done pulse. The grant is held until the winner drops its request.
//
// Optional feature macro: ATM_TXN_COUNT_EN
//   defined   -> txn_count counts transactions committed with ok=1 (wraps)
//   undefined -> txn_count is tied to zero and no counter register exists
//
// Parameters
//   BALANCE_INIT          balance loaded on reset
//
// Ports
//   clk                   clock, rising edge
//   rst                   asynchronous reset, active low
//   req[1:0]              request per controller, held until done is seen
//   op[1:0]               operation per controller: 0 deposit, 1 withdraw
//   monto_0, monto_1      unsigned 32-bit amounts for controller 0 / 1
//   gnt[1:0]              one-hot grant, zero when idle
//   done                  one-cycle pulse, result flags valid
//   ok                    balance updated (held until next capture)
//   fondos_insuficientes  withdraw rejected, amount above balance
//   desborde              deposit rejected, 64-bit overflow
//   balance[63:0]         registered balance
//   txn_count[15:0]       committed-transaction count
// -----------------------------------------------------------------------------
module atm_balance_arbiter #(
   parameter logic [63:0] BALANCE_INIT = 64'd4500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  op,
   input  logic [31:0] monto_0,
   input  logic [31:0] monto_1,
   output logic [1:0]  gnt,
   output logic        done,
   output logic        ok,
   output logic        fondos_insuficientes,
   output logic        desborde,
   output logic [63:0] balance,
   output logic [15:0] txn_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP,
      S_RELEASE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        win_q, win_d;       // index of the requester being served
   logic        last_q, last_d;     // index of the last requester served
   logic        op_q, op_d;
   logic [31:0] monto_q, monto_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        fi_q, fi_d;
   logic        ds_q, ds_d;
   logic [63:0] balance_q, balance_d;

   logic [63:0] amount;
   logic [64:0] sum;
   logic        pick;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      win_d     = win_q;
      last_d    = last_q;
      op_d      = op_q;
      monto_d   = monto_q;
      done_d    = 1'b0;
      ok_d      = ok_q;
      fi_d      = fi_q;
      ds_d      = ds_q;
      balance_d = balance_q;

      amount = {32'd0, monto_q};
      sum    = {1'b0, balance_q} + {1'b0, amount};
      // On a tie the requester opposite to the last one served wins;
      // otherwise the single active requester wins.
      pick   = (req == 2'b11) ? ~last_q : req[1];

      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               win_d   = pick;
               gnt_d   = pick ? 2'b10 : 2'b01;
               op_d    = op[pick];
               monto_d = pick ? monto_1 : monto_0;
               ok_d    = 1'b0;
               fi_d    = 1'b0;
               ds_d    = 1'b0;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            done_d = 1'b1;
            if (op_q) begin
               if (amount > balance_q) begin
                  fi_d = 1'b1;
               end else begin
                  balance_d = balance_q - amount;
                  ok_d      = 1'b1;
               end
            end else begin
               if (sum[64]) begin
                  ds_d = 1'b1;
               end else begin
                  balance_d = sum[63:0];
                  ok_d      = 1'b1;
               end
            end
            state_d = S_RESP;
         end

         S_RESP: begin
            state_d = S_RELEASE;
         end

         S_RELEASE: begin
            if (!req[win_q]) begin
               gnt_d   = 2'b00;
               last_d  = win_q;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         win_q     <= 1'b0;
         last_q    <= 1'b1;
         op_q      <= 1'b0;
         monto_q   <= '0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         fi_q      <= 1'b0;
         ds_q      <= 1'b0;
         balance_q <= BALANCE_INIT;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         win_q     <= win_d;
         last_q    <= last_d;
         op_q      <= op_d;
         monto_q   <= monto_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         fi_q      <= fi_d;
         ds_q      <= ds_d;
         balance_q <= balance_d;
      end
   end

`ifdef ATM_TXN_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Counts on the edge that raises done, so the count is current with done.
   always_comb begin
      cnt_d = cnt_q;
      if (done_d && ok_d) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign txn_count = cnt_q;
`else
   assign txn_count = '0;
`endif

   assign gnt                  = gnt_q;
   assign done                 = done_q;
   assign ok                   = ok_q;
   assign fondos_insuficientes = fi_q;
   assign desborde             = ds_q;
   assign balance              = balance_q;

endmodule

// File: tb/tb_atm_balance_arbiter.sv
module tb_atm_balance_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  op;
   logic [31:0] monto_0;
   logic [31:0] monto_1;
   logic [1:0]  gnt;
   logic        done;
   logic        ok;
   logic        fi;
   logic        ds;
   logic [63:0] balance;
   logic [15:0] txn_count;

   // second instance near the top of the 64-bit range
   logic [1:0]  req2;
   logic [1:0]  op2;
   logic [31:0] m2_0;
   logic [31:0] m2_1;
   logic [1:0]  gnt2;
   logic        done2;
   logic        ok2;
   logic        fi2;
   logic        ds2;
   logic [63:0] balance2;
   logic [15:0] txn_count2;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   atm_balance_arbiter #(.BALANCE_INIT(64'd4500)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op),
      .monto_0(monto_0), .monto_1(monto_1),
      .gnt(gnt), .done(done), .ok(ok),
      .fondos_insuficientes(fi), .desborde(ds),
      .balance(balance), .txn_count(txn_count)
   );

   atm_balance_arbiter #(.BALANCE_INIT(64'hFFFF_FFFF_FFFF_FFF6)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .op(op2),
      .monto_0(m2_0), .monto_1(m2_1),
      .gnt(gnt2), .done(done2), .ok(ok2),
      .fondos_insuficientes(fi2), .desborde(ds2),
      .balance(balance2), .txn_count(txn_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Transaction outcome is decided by plain arithmetic at capture time and
   // published one cycle later; m_age counts cycles since the capture.
   logic [63:0] m_bal;
   logic        m_last, m_win;
   int          m_age;
   logic [1:0]  m_gnt;
   logic        m_done, m_ok, m_fi, m_ds;
   logic [15:0] m_cnt;
   logic [63:0] m_res;
   logic        m_rok, m_rfi, m_rds;

   task automatic model_step();
      logic [63:0] amt;
      logic        wd;
      logic [64:0] wide;
      if (!rst) begin
         m_bal = 64'd4500; m_last = 1'b1; m_win = 1'b0; m_age = 0;
         m_gnt = 2'b00; m_done = 1'b0; m_ok = 1'b0; m_fi = 1'b0; m_ds = 1'b0;
         m_cnt = 16'd0;
      end else begin
         m_done = 1'b0;
         if (m_age == 0) begin
            if (req != 2'b00) begin
               if (req == 2'b11) m_win = !m_last;
               else              m_win = req[1];
               m_gnt = m_win ? 2'b10 : 2'b01;
               amt   = m_win ? {32'd0, monto_1} : {32'd0, monto_0};
               wd    = op[m_win];
               m_ok = 1'b0; m_fi = 1'b0; m_ds = 1'b0;
               m_rok = 1'b0; m_rfi = 1'b0; m_rds = 1'b0; m_res = m_bal;
               wide = {1'b0, m_bal} + {1'b0, amt};
               if (wd) begin
                  if (amt > m_bal) m_rfi = 1'b1;
                  else begin m_res = m_bal - amt; m_rok = 1'b1; end
               end else begin
                  if (wide > 65'h0_FFFF_FFFF_FFFF_FFFF) m_rds = 1'b1;
                  else begin m_res = wide[63:0]; m_rok = 1'b1; end
               end
               m_age = 1;
            end
         end else if (m_age == 1) begin
            m_bal = m_res; m_ok = m_rok; m_fi = m_rfi; m_ds = m_rds;
            m_done = 1'b1;
`ifdef ATM_TXN_COUNT_EN
            if (m_rok) m_cnt = m_cnt + 16'd1;
`endif
            m_age = 2;
         end else if (m_age == 2) begin
            m_age = 3;
         end else begin
            if (!req[m_win]) begin
               m_gnt = 2'b00; m_last = m_win; m_age = 0;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("cyc_gnt", {62'd0, gnt}, {62'd0, m_gnt});
         chk("cyc_done", {63'd0, done}, {63'd0, m_done});
         chk("cyc_ok", {63'd0, ok}, {63'd0, m_ok});
         chk("cyc_fondos", {63'd0, fi}, {63'd0, m_fi});
         chk("cyc_desborde", {63'd0, ds}, {63'd0, m_ds});
         chk("cyc_balance", balance, m_bal);
         chk("cyc_txn_count", {48'd0, txn_count}, {48'd0, m_cnt});
         if (done) done_cnt++;
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_done(input string name, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({name, "_done_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (gnt == 2'b00) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({name, "_idle_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic txn(input string name, input logic ch, input logic wd, input logic [31:0] amt);
      int n;
      @(negedge clk);
      if (ch) begin req = 2'b10; op[1] = wd; monto_1 = amt; end
      else    begin req = 2'b01; op[0] = wd; monto_0 = amt; end
      wait_done(name, n);
      @(negedge clk);
      req = 2'b00;
      wait_idle(name);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = 2'b00;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int n;
      int d0;
      bit seen2;
      rst = 1'b0; req = 2'b00; op = 2'b00; monto_0 = '0; monto_1 = '0;
      req2 = 2'b00; op2 = 2'b00; m2_0 = '0; m2_1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_balance", balance, 64'd4500);
      chk("rst_gnt", {62'd0, gnt}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_ok", {63'd0, ok}, 64'd0);
      chk("rst_txn", {48'd0, txn_count}, 64'd0);
      chk("rst_balance2", balance2, 64'hFFFF_FFFF_FFFF_FFF6);
      @(negedge clk);
      rst = 1'b1;

      // deposit 500 by controller 0; inputs disturbed after capture
      @(negedge clk);
      req = 2'b01; op = 2'b00; monto_0 = 32'd500;
      @(posedge clk);
      #1;
      chk("a_gnt", {62'd0, gnt}, 64'd1);
      monto_0 = 32'd9999; op = 2'b01;
      wait_done("a", n);
      chk("a_latency", 64'(n), 64'd1);
      chk("a_ok", {63'd0, ok}, 64'd1);
      chk("a_balance", balance, 64'd5000);
      @(negedge clk);
      req = 2'b00;
      wait_idle("a");

      // withdraw to exactly zero, then one too many
      txn("b1", 1'b1, 1'b1, 32'd500);
      chk("b1_balance", balance, 64'd4500);
      txn("b2", 1'b1, 1'b1, 32'd4500);
      chk("b2_ok", {63'd0, ok}, 64'd1);
      chk("b2_balance", balance, 64'd0);
      txn("b3", 1'b1, 1'b1, 32'd1);
      chk("b3_fondos", {63'd0, fi}, 64'd1);
      chk("b3_ok", {63'd0, ok}, 64'd0);
      chk("b3_balance", balance, 64'd0);
      txn("b4", 1'b0, 1'b0, 32'd0);
      chk("b4_ok", {63'd0, ok}, 64'd1);
      chk("b4_fondos", {63'd0, fi}, 64'd0);

      // simultaneous requests: round robin and pending loser
      do_reset();
      @(negedge clk);
      req = 2'b11; op = 2'b00; monto_0 = 32'd100; monto_1 = 32'd100;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      chk("c_gnt_first", {62'd0, gnt}, 64'd1);
      wait_done("c1", n);
      chk("c1_balance", balance, 64'd4600);
      @(negedge clk);
      req[0] = 1'b0;
      wait_idle("c1");
      req[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("c_gnt_tie", {62'd0, gnt}, 64'd2);
      wait_done("c2", n);
      chk("c2_balance", balance, 64'd4700);
      @(negedge clk);
      req[1] = 1'b0;
      wait_idle("c2");
      @(posedge clk);
      #1;
      chk("c_gnt_pending", {62'd0, gnt}, 64'd1);
      wait_done("c3", n);
      chk("c3_balance", balance, 64'd4800);
      @(negedge clk);
      req = 2'b00;
      wait_idle("c3");
      chk("c_done_pulses", 64'(done_cnt - d0), 64'd3);

      // reset in the middle of a withdraw
      do_reset();
      @(negedge clk);
      req = 2'b01; op = 2'b01; monto_0 = 32'd1000;
      @(posedge clk);
      #1;
      chk("d_gnt", {62'd0, gnt}, 64'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("d_abort_gnt", {62'd0, gnt}, 64'd0);
      chk("d_abort_done", {63'd0, done}, 64'd0);
      chk("d_abort_balance", balance, 64'd4500);
      req = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("d_no_done", 64'(done_cnt - d0), 64'd0);
      chk("d_balance_after", balance, 64'd4500);
      @(negedge clk);
      req = 2'b01; op = 2'b01; monto_0 = 32'd1000;
      wait_done("d2", n);
      chk("d2_balance", balance, 64'd3500);
      #1;
      rst = 1'b0;
      #1;
      chk("d2_done", {63'd0, done}, 64'd0);
      chk("d2_balance_reset", balance, 64'd4500);
      chk("d2_gnt", {62'd0, gnt}, 64'd0);
      req = 2'b00;
      @(negedge clk);
      rst = 1'b1;

      // committed-transaction count
      do_reset();
      txn("e1", 1'b0, 1'b0, 32'd1);
      txn("e2", 1'b0, 1'b0, 32'd2);
      txn("e3", 1'b0, 1'b0, 32'd3);
      txn("e4", 1'b1, 1'b1, 32'd100000);
      chk("e_fondos", {63'd0, fi}, 64'd1);
      chk("e_balance", balance, 64'd4506);
`ifdef ATM_TXN_COUNT_EN
      chk("e_txn_count", {48'd0, txn_count}, 64'd3);
`else
      chk("e_txn_count", {48'd0, txn_count}, 64'd0);
`endif

      // overflow on the high-balance instance
      @(negedge clk);
      req2 = 2'b01; op2 = 2'b00; m2_0 = 32'd20;
      seen2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done2) begin
            seen2 = 1'b1;
            break;
         end
      end
      if (!seen2) chk("f_done_timeout", 64'd0, 64'd1);
      chk("f_desborde", {63'd0, ds2}, 64'd1);
      chk("f_ok", {63'd0, ok2}, 64'd0);
      chk("f_balance", balance2, 64'hFFFF_FFFF_FFFF_FFF6);
      @(negedge clk);
      req2 = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("f_gnt_idle", {62'd0, gnt2}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
